// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared definitions for the Hack-style arithmetic/logic blocks.
//   HACK_WIDTH : native datapath width of the Hack machine (16 bits)
//   state_t    : state encoding used by the bit-serial units
//                IDLE=2'd0, SHIFT=2'd1, DONE=2'd2 (2'd3 unused, treated as IDLE)
// No ports (package).
// -----------------------------------------------------------------------------
package hack_pkg;

    localparam int HACK_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/or16_serial_or.sv
// -----------------------------------------------------------------------------
// _or
// Existing 1-bit OR gate primitive reused as the single bit operator of the
// serial OR unit.
// Ports:
//   a   in  1  first input bit
//   b   in  1  second input bit
//   out out 1  a | b
// -----------------------------------------------------------------------------
module _or (
    input  logic a,
    input  logic b,
    output logic out
);

    assign out = a | b;

endmodule

// File: rtl/or16_serial.sv
// -----------------------------------------------------------------------------
// or16_serial
// Bit-serial WIDTH-bit bitwise OR with valid/ready handshakes on both sides.
// An accepted operand pair is processed LSB first, one bit per clock, through a
// single _or gate; the result is held until the sink takes it.
// Latency: out_valid rises WIDTH cycles after the accepting edge; minimum
// WIDTH+2 cycles per operation with out_ready held high.
//
// Optional feature macro: OR16_SERIAL_ZR_EN
//   defined   -> adds the zr output (result all-zero flag, valid in DONE)
//   undefined -> no zr port, no any1 register
//
// Parameters:
//   WIDTH      operand/result width, >= 2 (default HACK_WIDTH = 16)
// Ports:
//   clk        in  1      rising-edge clock
//   rst_n      in  1      asynchronous active-low reset
//   in_valid   in  1      operand pair present
//   in_ready   out 1      block can accept an operand pair (IDLE)
//   a          in  WIDTH  operand A, sampled on the accepting edge only
//   b          in  WIDTH  operand B, sampled on the accepting edge only
//   out_valid  out 1      result present (DONE)
//   out_ready  in  1      sink takes the result
//   out        out WIDTH  result a | b, meaningful while out_valid=1
//   zr         out 1      result is all-zero (only with OR16_SERIAL_ZR_EN)
// -----------------------------------------------------------------------------
module or16_serial
    import hack_pkg::*;
#(
    parameter int WIDTH = HACK_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef OR16_SERIAL_ZR_EN
    ,
    output logic             zr
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             or_bit;
`ifdef OR16_SERIAL_ZR_EN
    logic             any1;
`endif

    // The only bit operator in the datapath: current LSBs of both shifters.
    _or u_or (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .out (or_bit)
    );

    // Control and datapath in one block. Result bits enter at the MSB and
    // move down, so after WIDTH shifts the first processed bit sits at bit 0.
    // The unused encoding 2'd3 behaves like IDLE via the default branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
`ifdef OR16_SERIAL_ZR_EN
            any1  <= 1'b0;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    res  <= {or_bit, res[WIDTH-1:1]};
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
`ifdef OR16_SERIAL_ZR_EN
                    if (or_bit) begin
                        any1 <= 1'b1;
                    end
`endif
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        res   <= '0;
                        cnt   <= '0;
`ifdef OR16_SERIAL_ZR_EN
                        any1  <= 1'b0;
`endif
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Handshake outputs are pure state decodes; no path from in_valid or
    // out_ready reaches any output.
    assign in_ready  = (state != SHIFT) && (state != DONE);
    assign out_valid = (state == DONE);
    assign out       = res;

`ifdef OR16_SERIAL_ZR_EN
    assign zr = (state == DONE) && !any1;
`endif

endmodule

// File: tb/tb_or16_serial.sv
// -----------------------------------------------------------------------------
// tb_or16_serial
// Directed-vector bench for or16_serial (WIDTH=16). zr checks are compiled in
// only when OR16_SERIAL_ZR_EN is defined.
// -----------------------------------------------------------------------------
module tb_or16_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
`ifdef OR16_SERIAL_ZR_EN
    logic        zr;
    logic        zr_cap;
`endif

    int errors;
    int checks;

    or16_serial #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef OR16_SERIAL_ZR_EN
        ,
        .zr        (zr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Run one operation with out_ready held high; returns the captured result
    // and the number of cycles from the accepting edge to out_valid.
    task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                          output logic [15:0] res, output int lat);
        int guard;
        out_ready = 1'b1;
        a         = va;
        b         = vb;
        in_valid  = 1'b1;
        guard     = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        lat      = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        res = out;
`ifdef OR16_SERIAL_ZR_EN
        zr_cap = zr;
`endif
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            a         = 16'($urandom);
            b         = 16'($urandom);
            tick();
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
            end
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL reset_out: got %h expected 0000", out);
            end
`ifdef OR16_SERIAL_ZR_EN
            checks++;
            if (zr !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_zr: got %b expected 0", zr);
            end
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        rst_n     = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got in_ready=%b out_valid=%b expected 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_basic;
        int cyc;
        a         = 16'h00F0;
        b         = 16'h0F01;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_ready_before: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_shift_flags: got in_ready=%b out_valid=%b expected 0/0",
                     in_ready, out_valid);
        end
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 16) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d cycles expected 16", cyc);
        end
        checks++;
        if (out !== 16'h0FF1) begin
            errors++;
            $display("[TB] FAIL basic_out: got %h expected 0ff1", out);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_ready_in_done: got %b expected 0", in_ready);
        end
`ifdef OR16_SERIAL_ZR_EN
        checks++;
        if (zr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_zr: got %b expected 0", zr);
        end
`endif
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_return_idle: got out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_zero_full;
        logic [15:0] res;
        int          lat;
        run_op(16'h0000, 16'h0000, res, lat);
        checks++;
        if (res !== 16'h0000 || lat != 16) begin
            errors++;
            $display("[TB] FAIL zero_out: got %h lat=%0d expected 0000 lat=16", res, lat);
        end
`ifdef OR16_SERIAL_ZR_EN
        checks++;
        if (zr_cap !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_zr: got %b expected 1", zr_cap);
        end
`endif
        run_op(16'hFFFF, 16'h8000, res, lat);
        checks++;
        if (res !== 16'hFFFF || lat != 16) begin
            errors++;
            $display("[TB] FAIL full_out: got %h lat=%0d expected ffff lat=16", res, lat);
        end
`ifdef OR16_SERIAL_ZR_EN
        checks++;
        if (zr_cap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_zr: got %b expected 0", zr_cap);
        end
`endif
    endtask

    task automatic test_backpressure;
        int cyc;
        int seen;
        out_ready = 1'b0;
        a         = 16'h0C30;
        b         = 16'h4005;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc      = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 16) begin
            errors++;
            $display("[TB] FAIL bp_latency: got %0d cycles expected 16", cyc);
        end
        a        = 16'h1234;
        b        = 16'h1234;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out !== 16'h4C35 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: got out_valid=%b out=%h in_ready=%b expected 1/4c35/0",
                         i, out_valid, out, in_ready);
            end
        end
        in_valid  = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL bp_single_completion: got %0d extra valid cycles expected 0", seen);
        end
    endtask

    task automatic test_mid_reset;
        logic [15:0] res;
        int          lat;
        int          seen;
        out_ready = 1'b1;
        a         = 16'hAAAA;
        b         = 16'h5555;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_busy: got in_ready=%b expected 0", in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midrst_async: got out_valid=%b in_ready=%b out=%h expected 0/1/0000",
                     out_valid, in_ready, out);
        end
        #1;
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL midrst_no_output: got %0d valid cycles expected 0", seen);
        end
        run_op(16'h0001, 16'h0002, res, lat);
        checks++;
        if (res !== 16'h0003 || lat != 16) begin
            errors++;
            $display("[TB] FAIL midrst_next_op: got %h lat=%0d expected 0003 lat=16", res, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] exp_res;
        int          guard;
        int          done;
        for (int n = 0; n < 1000; n++) begin
            ra       = 16'($urandom);
            rb       = 16'($urandom);
            exp_res  = ra | rb;
            a        = ra;
            b        = rb;
            in_valid = 1'b1;
            guard    = 0;
            while (in_ready !== 1'b1 && guard < 50) begin
                tick();
                guard++;
            end
            tick();
            in_valid = 1'b0;
            guard    = 0;
            done     = 0;
            while (done == 0 && guard < 200) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    checks++;
                    if (out !== exp_res) begin
                        errors++;
                        $display("[TB] FAIL rand_out[%0d]: got %h expected %h", n, out, exp_res);
                    end
                    done = 1;
                end
                tick();
                guard++;
            end
            if (done == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rand_timeout[%0d]: got no result expected %h", n, exp_res);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        test_reset();
        test_basic();
        test_zero_full();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
